// File: rtl/axi4lite_slave_regs_if.sv
// AXI4-Lite bus bundle between a master and the axi4lite_slave_regs register bank.
interface axi4lite_slave_regs_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
);
  logic                      AW_VALID;
  logic                      AW_READY;
  logic [AXI_ADDR_WIDTH-1:0] AW_ADDR;
  logic [2:0]                AW_PROT;
  logic                      W_VALID;
  logic                      W_READY;
  logic [AXI_DATA_WIDTH-1:0] W_DATA;
  logic [AXI_STRB_WIDTH-1:0] W_STRB;
  logic                      B_VALID;
  logic                      B_READY;
  logic [1:0]                B_RESP;
  logic                      AR_VALID;
  logic                      AR_READY;
  logic [AXI_ADDR_WIDTH-1:0] AR_ADDR;
  logic [2:0]                AR_PROT;
  logic                      R_VALID;
  logic                      R_READY;
  logic [AXI_DATA_WIDTH-1:0] R_DATA;
  logic [1:0]                R_RESP;

  modport master (
    output AW_VALID, AW_ADDR, AW_PROT, W_VALID, W_DATA, W_STRB, B_READY,
    output AR_VALID, AR_ADDR, AR_PROT, R_READY,
    input  AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
  );

  modport slave (
    input  AW_VALID, AW_ADDR, AW_PROT, W_VALID, W_DATA, W_STRB, B_READY,
    input  AR_VALID, AR_ADDR, AR_PROT, R_READY,
    output AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
  );
endinterface

// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite slave with a bank of 32-bit control/status registers; word 0 is a read-only ID.
// Write and read channels are independent two-state FSMs with registered responses.
module axi4lite_slave_regs #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int unsigned NUM_REGS       = 16,
  parameter logic [31:0] ID_VALUE       = 32'hA11E_0001
) (
  input  logic                               A_CLK,
  input  logic                               A_RSTn,
  axi4lite_slave_regs_if.slave               bus,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]                wr_stb
);
  localparam int unsigned IDX_W       = $clog2(NUM_REGS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE = 1'b0, WR_RESP = 1'b1} wr_state_t;
  typedef enum logic {RD_IDLE = 1'b0, RD_RESP = 1'b1} rd_state_t;

  // Address is in range when every bit above the register index is zero.
  function automatic logic addr_in_range(input logic [AXI_ADDR_WIDTH-1:0] addr);
    return (addr[AXI_ADDR_WIDTH-1:IDX_W+2] == '0);
  endfunction

  function automatic logic [AXI_DATA_WIDTH-1:0] merge_bytes(
    input logic [AXI_DATA_WIDTH-1:0] old_w,
    input logic [AXI_DATA_WIDTH-1:0] new_w,
    input logic [AXI_STRB_WIDTH-1:0] strb
  );
    logic [AXI_DATA_WIDTH-1:0] res;
    res = old_w;
    for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
      res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

  wr_state_t                 wr_state_r;
  rd_state_t                 rd_state_r;
  logic                      aw_held_r;
  logic                      w_held_r;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_r;
  logic [AXI_DATA_WIDTH-1:0] w_data_r;
  logic [AXI_STRB_WIDTH-1:0] w_strb_r;
  logic                      b_valid_r;
  logic [1:0]                b_resp_r;
  logic                      r_valid_r;
  logic [1:0]                r_resp_r;
  logic [AXI_DATA_WIDTH-1:0] r_data_r;
  logic [NUM_REGS-1:0]       wr_stb_r;
  logic [AXI_DATA_WIDTH-1:0] regs_r [NUM_REGS];
  logic [AXI_DATA_WIDTH-1:0] rd_word_s [NUM_REGS];

  logic                      aw_hs_s;
  logic                      w_hs_s;
  logic                      ar_hs_s;
  logic                      commit_s;
  logic                      wr_ok_s;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr_s;
  logic [AXI_DATA_WIDTH-1:0] wr_data_s;
  logic [AXI_STRB_WIDTH-1:0] wr_strb_s;
  logic [IDX_W-1:0]          wr_idx_s;
  logic [IDX_W-1:0]          rd_idx_s;
  logic                      unused_s;

  assign bus.AW_READY = (wr_state_r == WR_IDLE) & ~aw_held_r;
  assign bus.W_READY  = (wr_state_r == WR_IDLE) & ~w_held_r;
  assign bus.AR_READY = (rd_state_r == RD_IDLE);
  assign bus.B_VALID  = b_valid_r;
  assign bus.B_RESP   = b_resp_r;
  assign bus.R_VALID  = r_valid_r;
  assign bus.R_RESP   = r_resp_r;
  assign bus.R_DATA   = r_data_r;
  assign wr_stb       = wr_stb_r;

  assign aw_hs_s  = bus.AW_VALID & bus.AW_READY;
  assign w_hs_s   = bus.W_VALID & bus.W_READY;
  assign ar_hs_s  = bus.AR_VALID & bus.AR_READY;

  // A half already latched takes precedence over the live bus for the other half.
  assign wr_addr_s = aw_held_r ? aw_addr_r : bus.AW_ADDR;
  assign wr_data_s = w_held_r ? w_data_r : bus.W_DATA;
  assign wr_strb_s = w_held_r ? w_strb_r : bus.W_STRB;
  assign wr_idx_s  = wr_addr_s[IDX_W+1:2];
  assign rd_idx_s  = bus.AR_ADDR[IDX_W+1:2];
  assign commit_s  = (wr_state_r == WR_IDLE) & (aw_held_r | aw_hs_s) & (w_held_r | w_hs_s);
  assign wr_ok_s   = addr_in_range(wr_addr_s) & (wr_idx_s != '0);

  assign unused_s = ^{bus.AW_PROT, bus.AR_PROT, wr_addr_s[1:0], bus.AR_ADDR[1:0]};

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_rd_word
    if (i == 0) begin : g_id
      assign rd_word_s[i] = ID_VALUE;
    end else begin : g_reg
      assign rd_word_s[i] = regs_r[i];
    end
    assign reg_q[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = rd_word_s[i];
  end

  // Write channel: latch AW/W independently, commit when both are present, then respond.
  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) begin
      wr_state_r <= WR_IDLE;
      aw_held_r  <= 1'b0;
      w_held_r   <= 1'b0;
      aw_addr_r  <= '0;
      w_data_r   <= '0;
      w_strb_r   <= '0;
      b_valid_r  <= 1'b0;
      b_resp_r   <= RESP_OKAY;
      wr_stb_r   <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      wr_stb_r <= '0;
      case (wr_state_r)
        WR_IDLE: begin
          if (aw_hs_s) begin
            aw_held_r <= 1'b1;
            aw_addr_r <= bus.AW_ADDR;
          end
          if (w_hs_s) begin
            w_held_r <= 1'b1;
            w_data_r <= bus.W_DATA;
            w_strb_r <= bus.W_STRB;
          end
          if (commit_s) begin
            wr_state_r <= WR_RESP;
            b_valid_r  <= 1'b1;
            if (wr_ok_s) begin
              regs_r[wr_idx_s]   <= merge_bytes(regs_r[wr_idx_s], wr_data_s, wr_strb_s);
              wr_stb_r[wr_idx_s] <= 1'b1;
              b_resp_r           <= RESP_OKAY;
            end else begin
              b_resp_r <= RESP_SLVERR;
            end
          end
        end
        WR_RESP: begin
          if (bus.B_READY) begin
            b_valid_r  <= 1'b0;
            aw_held_r  <= 1'b0;
            w_held_r   <= 1'b0;
            wr_state_r <= WR_IDLE;
          end
        end
        default: begin
          wr_state_r <= WR_IDLE;
        end
      endcase
    end
  end

  // Read channel: sample the register bank on the AR handshake and hold until R_READY.
  always_ff @(posedge A_CLK or negedge A_RSTn) begin
    if (!A_RSTn) begin
      rd_state_r <= RD_IDLE;
      r_valid_r  <= 1'b0;
      r_resp_r   <= RESP_OKAY;
      r_data_r   <= '0;
    end else begin
      case (rd_state_r)
        RD_IDLE: begin
          if (ar_hs_s) begin
            rd_state_r <= RD_RESP;
            r_valid_r  <= 1'b1;
            if (addr_in_range(bus.AR_ADDR)) begin
              r_data_r <= rd_word_s[rd_idx_s];
              r_resp_r <= RESP_OKAY;
            end else begin
              r_data_r <= '0;
              r_resp_r <= RESP_SLVERR;
            end
          end
        end
        RD_RESP: begin
          if (bus.R_READY) begin
            r_valid_r  <= 1'b0;
            rd_state_r <= RD_IDLE;
          end
        end
        default: begin
          rd_state_r <= RD_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Directed bench for axi4lite_slave_regs: a vector table plus hand-written multi-cycle sequences.
module tb_axi4lite_slave_regs;
  localparam int NR = 16;
  localparam logic [31:0] ID = 32'hA11E_0001;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR*32-1:0]  reg_q;
  logic [NR-1:0]     wr_stb;
  int                checks_n = 0;
  int                errors_n = 0;

  axi4lite_slave_regs_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) bus ();

  axi4lite_slave_regs #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_STRB_WIDTH(4),
    .NUM_REGS(NR), .ID_VALUE(ID)
  ) dut (
    .A_CLK(clk), .A_RSTn(rst_n), .bus(bus), .reg_q(reg_q), .wr_stb(wr_stb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic [15:0] exp_stb;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_n++;
    if (act !== exp) begin
      errors_n++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output logic [15:0] stb);
    logic aw_go, w_go, aw_done, w_done, got;
    aw_done = 1'b0; w_done = 1'b0; got = 1'b0; resp = 2'b11; stb = '0;
    bus.AW_ADDR = addr; bus.W_DATA = data; bus.W_STRB = strb;
    bus.AW_VALID = 1'b1; bus.W_VALID = 1'b1;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      @(negedge clk);
      aw_go = bus.AW_VALID & bus.AW_READY;
      w_go  = bus.W_VALID & bus.W_READY;
      @(posedge clk); #1;
      if (aw_go) begin bus.AW_VALID = 1'b0; aw_done = 1'b1; end
      if (w_go)  begin bus.W_VALID = 1'b0;  w_done = 1'b1;  end
    end
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.B_VALID) begin got = 1'b1; resp = bus.B_RESP; stb = wr_stb; end
      @(posedge clk); #1;
    end
    if (!got) check("write_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    logic go, done, got;
    done = 1'b0; got = 1'b0; data = 32'hxxxx_xxxx; resp = 2'b11;
    bus.AR_ADDR = addr; bus.AR_VALID = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      go = bus.AR_VALID & bus.AR_READY;
      @(posedge clk); #1;
      if (go) begin bus.AR_VALID = 1'b0; done = 1'b1; end
    end
    bus.AR_VALID = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.R_VALID) begin got = 1'b1; data = bus.R_DATA; resp = bus.R_RESP; end
      @(posedge clk); #1;
    end
    if (!got) check("read_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] rd_d;
    logic [1:0]  rsp;
    logic [15:0] stb;

    bus.AW_VALID = 1'b0; bus.AW_ADDR = '0; bus.AW_PROT = 3'd0;
    bus.W_VALID = 1'b0;  bus.W_DATA = '0;  bus.W_STRB = 4'h0;
    bus.B_READY = 1'b1;
    bus.AR_VALID = 1'b0; bus.AR_ADDR = '0; bus.AR_PROT = 3'd0;
    bus.R_READY = 1'b1;

    //                  wr    addr           data           strb     exp_data       resp   stb
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'h0,    32'hA11E_0001, 2'b00, 16'h0000});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF,    32'h0,         2'b10, 16'h0000});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'h0,    32'hA11E_0001, 2'b00, 16'h0000});
    vecs.push_back('{1'b0, 32'h0000_0040, 32'h0,         4'h0,    32'h0,         2'b10, 16'h0000});
    vecs.push_back('{1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF,    32'h0,         2'b10, 16'h0000});
    vecs.push_back('{1'b1, 32'h0000_0014, 32'hA5A5_A5A5, 4'b1000, 32'h0,         2'b00, 16'h0020});
    vecs.push_back('{1'b0, 32'h0000_0014, 32'h0,         4'h0,    32'hA500_0000, 2'b00, 16'h0000});
    vecs.push_back('{1'b1, 32'h0000_0014, 32'h1111_1111, 4'h0,    32'h0,         2'b00, 16'h0020});
    vecs.push_back('{1'b0, 32'h0000_0014, 32'h0,         4'h0,    32'hA500_0000, 2'b00, 16'h0000});
    vecs.push_back('{1'b1, 32'h0000_003C, 32'h0F0F_0F0F, 4'hF,    32'h0,         2'b00, 16'h8000});
    vecs.push_back('{1'b0, 32'h0000_003F, 32'h0,         4'h0,    32'h0F0F_0F0F, 2'b00, 16'h0000});
    vecs.push_back('{1'b0, 32'h1000_0004, 32'h0,         4'h0,    32'h0,         2'b10, 16'h0000});
    vecs.push_back('{1'b1, 32'h0000_0044, 32'h0000_0099, 4'hF,    32'h0,         2'b10, 16'h0000});
    vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,         4'h0,    32'hDEAD_BEEF, 2'b00, 16'h0000});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'h0,    32'h0000_0055, 2'b00, 16'h0000});

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_bvalid", bus.B_VALID, 32'd0);
    check("rst_rvalid", bus.R_VALID, 32'd0);
    check("rst_bresp", bus.B_RESP, 32'd0);
    check("rst_rresp", bus.R_RESP, 32'd0);
    check("rst_rdata", bus.R_DATA, 32'd0);
    check("rst_wrstb", wr_stb, 32'd0);
    check("rst_awready", bus.AW_READY, 32'd1);
    check("rst_wready", bus.W_READY, 32'd1);
    check("rst_arready", bus.AR_READY, 32'd1);
    check("rst_reg0", reg_q[31:0], ID);
    for (int i = 1; i < NR; i++) check($sformatf("rst_reg%0d", i), reg_q[32*i +: 32], 32'd0);
    @(posedge clk); #1;

    // AW and W in the same cycle
    bus.AW_ADDR = 32'h4; bus.W_DATA = 32'hDEAD_BEEF; bus.W_STRB = 4'hF;
    bus.AW_VALID = 1'b1; bus.W_VALID = 1'b1;
    @(posedge clk); #1;
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
    @(negedge clk);
    check("same_bvalid", bus.B_VALID, 32'd1);
    check("same_bresp", bus.B_RESP, 32'd0);
    check("same_reg1", reg_q[63:32], 32'hDEAD_BEEF);
    check("same_wrstb", wr_stb, 32'h0002);
    @(posedge clk); #1;
    @(negedge clk);
    check("same_wrstb_once", wr_stb, 32'h0000);
    check("same_bvalid_drop", bus.B_VALID, 32'd0);
    @(posedge clk); #1;
    do_read(32'h4, rd_d, rsp);
    check("same_rd_data", rd_d, 32'hDEAD_BEEF);
    check("same_rd_resp", rsp, 32'd0);

    // W three cycles ahead of AW; W payload must come from the latch
    bus.W_DATA = 32'h1234_5678; bus.W_STRB = 4'b0101; bus.W_VALID = 1'b1;
    @(posedge clk); #1;
    bus.W_VALID = 1'b0; bus.W_DATA = 32'hFFFF_FFFF; bus.W_STRB = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("wfirst_wready_%0d", i), bus.W_READY, 32'd0);
      check($sformatf("wfirst_awready_%0d", i), bus.AW_READY, 32'd1);
      check($sformatf("wfirst_bvalid_%0d", i), bus.B_VALID, 32'd0);
      check($sformatf("wfirst_reg2_%0d", i), reg_q[95:64], 32'd0);
      @(posedge clk); #1;
    end
    bus.AW_ADDR = 32'h8; bus.AW_VALID = 1'b1;
    @(posedge clk); #1;
    bus.AW_VALID = 1'b0;
    @(negedge clk);
    check("wfirst_bvalid", bus.B_VALID, 32'd1);
    check("wfirst_bresp", bus.B_RESP, 32'd0);
    check("wfirst_reg2", reg_q[95:64], 32'h0034_0078);
    check("wfirst_wrstb", wr_stb, 32'h0004);
    @(posedge clk); #1;

    // B_READY held low; second write waits for the B handshake
    bus.B_READY = 1'b0;
    bus.AW_ADDR = 32'hC; bus.W_DATA = 32'hCAFE_F00D; bus.W_STRB = 4'hF;
    bus.AW_VALID = 1'b1; bus.W_VALID = 1'b1;
    @(posedge clk); #1;
    bus.AW_ADDR = 32'h10; bus.W_DATA = 32'h0000_0055;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bstall_bvalid_%0d", i), bus.B_VALID, 32'd1);
      check($sformatf("bstall_bresp_%0d", i), bus.B_RESP, 32'd0);
      check($sformatf("bstall_awready_%0d", i), bus.AW_READY, 32'd0);
      check($sformatf("bstall_wready_%0d", i), bus.W_READY, 32'd0);
      @(posedge clk); #1;
    end
    bus.B_READY = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bstall_bvalid_drop", bus.B_VALID, 32'd0);
    check("bstall_awready_back", bus.AW_READY, 32'd1);
    check("bstall_wready_back", bus.W_READY, 32'd1);
    @(posedge clk); #1;
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
    @(negedge clk);
    check("bstall2_bvalid", bus.B_VALID, 32'd1);
    check("bstall2_bresp", bus.B_RESP, 32'd0);
    check("bstall2_reg3", reg_q[127:96], 32'hCAFE_F00D);
    check("bstall2_reg4", reg_q[159:128], 32'h0000_0055);
    @(posedge clk); #1;

    // Vector table
    foreach (vecs[k]) begin
      if (vecs[k].is_wr) begin
        do_write(vecs[k].addr, vecs[k].data, vecs[k].strb, rsp, stb);
        check($sformatf("vec%0d_bresp", k), rsp, vecs[k].exp_resp);
        check($sformatf("vec%0d_wrstb", k), stb, vecs[k].exp_stb);
      end else begin
        do_read(vecs[k].addr, rd_d, rsp);
        check($sformatf("vec%0d_rdata", k), rd_d, vecs[k].exp_data);
        check($sformatf("vec%0d_rresp", k), rsp, vecs[k].exp_resp);
      end
    end
    check("vec_id_intact", reg_q[31:0], ID);

    // Read stalled by R_READY while a write to the same register commits on the AR edge
    bus.R_READY = 1'b0;
    bus.AR_ADDR = 32'hC; bus.AR_VALID = 1'b1;
    bus.AW_ADDR = 32'hC; bus.W_DATA = 32'h600D_D00D; bus.W_STRB = 4'hF;
    bus.AW_VALID = 1'b1; bus.W_VALID = 1'b1;
    @(posedge clk); #1;
    bus.AR_VALID = 1'b0; bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rstall_rvalid_%0d", i), bus.R_VALID, 32'd1);
      check($sformatf("rstall_rdata_%0d", i), bus.R_DATA, 32'hCAFE_F00D);
      check($sformatf("rstall_arready_%0d", i), bus.AR_READY, 32'd0);
      @(posedge clk); #1;
    end
    check("rstall_reg3_new", reg_q[127:96], 32'h600D_D00D);
    bus.R_READY = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstall_rvalid_drop", bus.R_VALID, 32'd0);
    @(posedge clk); #1;
    do_read(32'hC, rd_d, rsp);
    check("rstall_reread", rd_d, 32'h600D_D00D);

    // Asynchronous reset with both responses pending
    bus.B_READY = 1'b0; bus.R_READY = 1'b0;
    bus.AW_ADDR = 32'h18; bus.W_DATA = 32'h0000_0077; bus.W_STRB = 4'hF;
    bus.AW_VALID = 1'b1; bus.W_VALID = 1'b1;
    bus.AR_ADDR = 32'h4; bus.AR_VALID = 1'b1;
    @(posedge clk); #1;
    bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0; bus.AR_VALID = 1'b0;
    @(negedge clk);
    check("arst_pre_bvalid", bus.B_VALID, 32'd1);
    check("arst_pre_rvalid", bus.R_VALID, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_bvalid", bus.B_VALID, 32'd0);
    check("arst_rvalid", bus.R_VALID, 32'd0);
    check("arst_rdata", bus.R_DATA, 32'd0);
    check("arst_reg0", reg_q[31:0], ID);
    for (int i = 1; i < NR; i++) check($sformatf("arst_reg%0d", i), reg_q[32*i +: 32], 32'd0);
    @(negedge clk);
    rst_n = 1'b1; bus.B_READY = 1'b1; bus.R_READY = 1'b1;
    @(negedge clk);
    check("arst_awready", bus.AW_READY, 32'd1);
    check("arst_wready", bus.W_READY, 32'd1);
    check("arst_arready", bus.AR_READY, 32'd1);
    check("arst_bvalid_after", bus.B_VALID, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors_n, checks_n);
    $finish;
  end
endmodule
